alu_div_scheduler: RTL and testbench
====================================

ALU_DIV_SCHEDULER -- requirements
Module: alu_div_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the maximum WAIT cycles before a divider fault is declared.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port res  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  requester operand pair valid.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  dividend and divisor, half-precision.
REQ-007 The block SHALL have ports req0_ready / req1_ready  output  1  one-cycle acceptance pulse.
REQ-008 The block SHALL have ports alu_a, alu_b  output  1  serial operand bits to the divider, MSB first.
REQ-009 The block SHALL have port alu_tvalid  output  1  serial operand bit valid.
REQ-010 The block SHALL have port alu_tready  input  1  divider result streaming.
REQ-011 The block SHALL have port alu_out  input  1  divider serial result bit.
REQ-012 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  WIDTH, rsp_id  output  1, rsp_err  output  1, forming the response channel.
REQ-013 The block SHALL have port busy  output  1, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, WAIT, CAPTURE and RESP.
REQ-015 In IDLE, with any reqN_valid high, the block SHALL grant one requester round-robin, pulse its reqN_ready, latch a/b and id, clear the bit counter and enter SHIFT next cycle.
REQ-016 With both requests valid, the block SHALL grant the requester not granted last; after reset, last-grant SHALL be 1, so req0 wins first.
REQ-017 In SHIFT, the block SHALL hold alu_tvalid high for exactly WIDTH cycles, driving bit WIDTH-1-k of a/b on cycle k, then enter WAIT.
REQ-018 In WAIT, the block SHALL count cycles from 0; alu_tready high SHALL enter CAPTURE, and reaching TIMEOUT SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-019 If alu_tready is already high on the first WAIT cycle, that alu_out bit SHALL be the first captured bit.
REQ-020 In CAPTURE, the block SHALL sample alu_out for WIDTH consecutive cycles, the first bit landing in rsp_data[WIDTH-1], then enter RESP with rsp_err=0.
REQ-021 alu_tready falling during CAPTURE SHALL be ignored; capture SHALL always complete WIDTH bits.
REQ-022 In RESP, rsp_valid SHALL stay high with rsp_data, rsp_id and rsp_err stable until rsp_ready is sampled high, then the block SHALL return to IDLE.
REQ-023 No new grant SHALL occur in the cycle rsp_ready is accepted; the earliest next grant SHALL be the following IDLE cycle.
REQ-024 Requests arriving outside IDLE SHALL be held off with reqN_ready low and no loss of requester state.
REQ-025 Latency SHALL be 1 grant cycle + WIDTH shift cycles + WAIT cycles + WIDTH capture cycles until rsp_valid.

Reset
REQ-026 Asserting res low SHALL immediately force IDLE, with all counters 0, last-grant 1, and alu_a, alu_b, alu_tvalid, reqN_ready, rsp_valid, rsp_err, rsp_id and busy at 0, and rsp_data at 0.
REQ-027 Reset mid-transfer SHALL abandon the operation without emitting a response; deassertion SHALL be sampled synchronously.

Structure
REQ-028 The FSM state encoding, WIDTH default and TIMEOUT default SHALL live in shared package alu_div_pkg.
REQ-029 The round-robin grant logic SHALL be a sub-module named rr_arbiter2.

Verification
REQ-030 The bench SHALL check: req0 a=0x3C00, b=0x4000, with a model returning 0x3800 after 5 WAIT cycles -> rsp_data=0x3800, rsp_id=0, rsp_err=0, rsp_valid on cycle 1+16+5+16.
REQ-031 The bench SHALL check: req0 and req1 valid together, held for two operations -> grant order req0 then req1, and rsp_id 0 then 1.
REQ-032 The bench SHALL check: alu_tready never asserted -> rsp_valid after exactly 64 WAIT cycles, with rsp_err=1 and rsp_data=0x0000.
REQ-033 The bench SHALL check: rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable throughout, and no grant to a pending req1.
REQ-034 The bench SHALL check: res low during CAPTURE bit 7 -> all outputs 0 in the same cycle, no response emitted, and a fresh req0 accepted after release.
REQ-035 The bench SHALL check: a=0xA5A5 -> alu_a serial pattern 1,0,1,0,0,1,0,1,... with alu_tvalid high for exactly 16 cycles.

Source files
------------

// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared FSM encoding and default sizing for the
// serial divider scheduler (alu_div_scheduler and its helpers).
package alu_div_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_div_scheduler_if.sv
// alu_div_scheduler_if: requester, serial divider and response signals.
// master = scheduler side, slave = requesters / divider / consumer side.
interface alu_div_scheduler_if #(
    parameter int WIDTH = alu_div_pkg::DEF_WIDTH
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_ready;
    logic             req1_ready;
    logic             alu_a;
    logic             alu_b;
    logic             alu_tvalid;
    logic             alu_tready;
    logic             alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_err;
    logic             busy;

    modport master (
        input  req0_valid, req1_valid,
        input  req0_a, req0_b, req1_a, req1_b,
        input  alu_tready, alu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_tvalid,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        output busy
    );

    modport slave (
        output req0_valid, req1_valid,
        output req0_a, req0_b, req1_a, req1_b,
        output alu_tready, alu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_tvalid,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        input  busy
    );

endinterface

// File: rtl/alu_div_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, last-grant resets to 1.
// Ports: clk, rst_n, req_i[1:0], en_i (grant taken), gnt_o[1:0] one-hot.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: favour whoever was not served last.
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_div_scheduler.sv
// alu_div_scheduler: arbitrates two operand requesters onto a bit-serial
// divider and returns its result. Ports: clk, res (async, low), bus.master.
module alu_div_scheduler
    import alu_div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 res,
    alu_div_scheduler_if.master bus
);

    localparam int BCW = cnt_bits(WIDTH);
    localparam int TCW = cnt_bits(TIMEOUT);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [TCW-1:0]   wait_q, wait_d;

    logic [1:0] req_vec;
    logic [1:0] gnt;
    logic       accept;
    logic       in_shift;

    assign req_vec = {bus.req1_valid, bus.req0_valid};

    // Ready is combinational so the pulse lands in the grant cycle;
    // gating with res keeps it low while reset is asserted.
    assign accept = (state_q == ST_IDLE) && res && (|req_vec);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (res),
        .req_i (req_vec),
        .en_i  (accept),
        .gnt_o (gnt)
    );

    assign in_shift = (state_q == ST_SHIFT);

    assign bus.req0_ready = accept & gnt[0];
    assign bus.req1_ready = accept & gnt[1];
    assign bus.alu_tvalid = in_shift;
    assign bus.alu_a      = in_shift & a_q[WIDTH-1];
    assign bus.alu_b      = in_shift & b_q[WIDTH-1];
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = gnt[1] ? bus.req1_a : bus.req0_a;
                    b_d     = gnt[1] ? bus.req1_b : bus.req0_b;
                    id_d    = gnt[1];
                    data_d  = '0;
                    err_d   = 1'b0;
                    bit_d   = '0;
                    wait_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Operands shift left so the MSB is always on the wire.
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                b_d   = {b_q[WIDTH-2:0], 1'b0};
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.alu_tready) begin
                    // This cycle already carries the first result bit.
                    data_d  = {data_q[WIDTH-2:0], bus.alu_out};
                    bit_d   = BCW'(1);
                    state_d = ST_CAPTURE;
                end else if (wait_q == WAIT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                // alu_tready is deliberately ignored here.
                data_d = {data_q[WIDTH-2:0], bus.alu_out};
                bit_d  = bit_q + 1'b1;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            bit_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_alu_div_scheduler.sv
// tb_alu_div_scheduler: directed bench with a timeline model of the
// scheduler and a divider stub driven from that model.
module tb_alu_div_scheduler;
    import alu_div_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int TO = DEF_TIMEOUT;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int         cfg_wl = 0;
    logic [W-1:0] cfg_res = '0;
    bit         cfg_drop = 1'b0;

    bit         m_active = 1'b0;
    bit         m_last = 1'b1;
    bit         m_id = 1'b0;
    bit         m_err = 1'b0;
    bit         m_drop = 1'b0;
    int         m_g = 0;
    int         m_wl = 0;
    int         m_rsp_at = 0;
    int         m_free_at = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_res = '0;

    alu_div_scheduler_if #(.WIDTH(W)) bus ();

    alu_div_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int lim,
                            input string nm, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = bus.req0_ready;
                1:       hit = bus.req1_ready;
                2:       hit = bus.rsp_valid;
                default: hit = bus.req0_ready | bus.req1_ready;
            endcase
            if (hit === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event within %0d cycles", nm, lim);
        end
    endtask

    // Model: a grant at cycle g implies shift on g+1..g+W, result
    // window from g+1+W+wl, response at a fixed offset after that.
    always @(negedge clk) begin : cmp
        int   k;
        int   j;
        logic e_r0, e_r1, e_tv, e_a, e_b, e_rv, e_busy;
        if (!res) begin
            m_active  = 1'b0;
            m_last    = 1'b1;
            m_free_at = 0;
            bus.alu_tready = 1'b0;
            bus.alu_out    = 1'b0;
            chk("rst_busy", bus.busy, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_tvalid", bus.alu_tvalid, 0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_ready0", bus.req0_ready, 0);
        end else begin
            if (!m_active && cyc >= m_free_at &&
                (bus.req0_valid || bus.req1_valid)) begin
                m_id = (bus.req0_valid && bus.req1_valid) ? !m_last
                                                          : bus.req1_valid;
                m_last   = m_id;
                m_active = 1'b1;
                m_g      = cyc;
                m_a      = m_id ? bus.req1_a : bus.req0_a;
                m_b      = m_id ? bus.req1_b : bus.req0_b;
                m_wl     = cfg_wl;
                m_res    = cfg_res;
                m_drop   = cfg_drop;
                m_err    = (m_wl >= TO);
                m_rsp_at = m_err ? m_g + 1 + W + TO : m_g + 1 + W + m_wl + W;
            end
            k      = cyc - m_g - 1;
            e_r0   = m_active && cyc == m_g && !m_id;
            e_r1   = m_active && cyc == m_g && m_id;
            e_tv   = m_active && k >= 0 && k < W;
            e_a    = 1'b0;
            e_b    = 1'b0;
            if (e_tv) begin
                e_a = m_a[W-1-k];
                e_b = m_b[W-1-k];
            end
            e_rv   = m_active && cyc >= m_rsp_at;
            e_busy = m_active && cyc > m_g;
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("alu_tvalid", bus.alu_tvalid, e_tv);
            chk("alu_a", bus.alu_a, e_a);
            chk("alu_b", bus.alu_b, e_b);
            chk("rsp_valid", bus.rsp_valid, e_rv);
            chk("busy", bus.busy, e_busy);
            if (e_rv) begin
                chk("rsp_data", bus.rsp_data, m_err ? '0 : m_res);
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_err", bus.rsp_err, m_err);
                if (bus.rsp_ready) begin
                    m_active  = 1'b0;
                    m_free_at = cyc + 1;
                end
            end
            j = cyc - (m_g + 1 + W + m_wl);
            bus.alu_tready = 1'b0;
            bus.alu_out    = 1'b0;
            if (m_active && !m_err && j >= 0 && j < W) begin
                bus.alu_tready = !(m_drop && j >= 3 && j <= 8);
                bus.alu_out    = m_res[W-1-j];
            end
        end
    end

    initial begin : drv
        int   g, g2, r, r2, at, cnt, bad, r1cnt;
        logic id_a, id_b, rid_a, rid_b;
        logic [W-1:0] sa, sb;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
        #1 res = 1'b0;
        #1;
        chk("init_busy", bus.busy, 0);
        chk("init_rsp_valid", bus.rsp_valid, 0);
        chk("init_tvalid", bus.alu_tvalid, 0);
        chk("init_rsp_data", bus.rsp_data, 0);
        repeat (3) @(posedge clk);
        #1 res = 1'b1;

        // Both requesters held valid across two operations.
        cfg_wl = 2;
        cfg_res = 16'h1111;
        cfg_drop = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_a = 16'h0101;
        bus.req0_b = 16'h0001;
        bus.req1_a = 16'h0202;
        bus.req1_b = 16'h0002;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_for(3, 5, "rr_grant1", g);
        id_a = bus.req1_ready;
        wait_for(2, 80, "rr_rsp1", r);
        rid_a = bus.rsp_id;
        wait_for(3, 5, "rr_grant2", g2);
        id_b = bus.req1_ready;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_for(2, 80, "rr_rsp2", r2);
        rid_b = bus.rsp_id;
        chk("rr_first_grant_id", id_a, 0);
        chk("rr_second_grant_id", id_b, 1);
        chk("rr_rsp1_id", rid_a, 0);
        chk("rr_rsp2_id", rid_b, 1);
        chk("rr_regrant_gap", g2 - r, 1);

        // 1.0 / 2.0 style operands, result after five idle WAIT cycles.
        step();
        cfg_wl = 5;
        cfg_res = 16'h3800;
        bus.req0_a = 16'h3C00;
        bus.req0_b = 16'h4000;
        bus.req0_valid = 1'b1;
        wait_for(0, 5, "t1_grant", g);
        step();
        bus.req0_valid = 1'b0;
        wait_for(2, 80, "t1_rsp", r);
        chk("t1_data", bus.rsp_data, 16'h3800);
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_err", bus.rsp_err, 0);
        chk("t1_latency", r - g, 38);

        // Serial pattern, tready on first WAIT cycle, tready dropouts.
        step();
        cfg_wl = 0;
        cfg_res = 16'h1234;
        cfg_drop = 1'b1;
        bus.req0_a = 16'hA5A5;
        bus.req0_b = 16'h0F0F;
        bus.req0_valid = 1'b1;
        wait_for(0, 5, "t2_grant", g);
        step();
        bus.req0_valid = 1'b0;
        cnt = 0;
        sa = '0;
        sb = '0;
        repeat (20) begin
            @(negedge clk);
            if (bus.alu_tvalid === 1'b1) begin
                sa = {sa[W-2:0], bus.alu_a};
                sb = {sb[W-2:0], bus.alu_b};
                cnt++;
            end
        end
        wait_for(2, 40, "t2_rsp", r);
        chk("t2_alu_a_bits", sa, 16'hA5A5);
        chk("t2_alu_b_bits", sb, 16'h0F0F);
        chk("t2_tvalid_cycles", cnt, 16);
        chk("t2_data", bus.rsp_data, 16'h1234);
        chk("t2_latency", r - g, 33);

        // Divider never answers.
        step();
        cfg_wl = 1000;
        cfg_drop = 1'b0;
        cfg_res = 16'hFFFF;
        bus.req0_a = 16'h0001;
        bus.req0_b = 16'h0000;
        bus.req0_valid = 1'b1;
        wait_for(0, 5, "t3_grant", g);
        step();
        bus.req0_valid = 1'b0;
        wait_for(2, 120, "t3_rsp", r);
        chk("t3_err", bus.rsp_err, 1);
        chk("t3_data", bus.rsp_data, 16'h0000);
        chk("t3_latency", r - g, 81);

        // Response back-pressure with req1 pending.
        step();
        bus.rsp_ready = 1'b0;
        cfg_wl = 4;
        cfg_res = 16'hBEEF;
        bus.req0_a = 16'h00AA;
        bus.req0_b = 16'h0005;
        bus.req0_valid = 1'b1;
        wait_for(0, 5, "t4_grant", g);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_a = 16'h0077;
        bus.req1_b = 16'h0007;
        bus.req1_valid = 1'b1;
        wait_for(2, 60, "t4_rsp", r);
        bad = 0;
        r1cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF) bad++;
            if (bus.req1_ready === 1'b1) r1cnt++;
        end
        chk("t4_hold_stable", bad, 0);
        chk("t4_no_grant_req1", r1cnt, 0);
        step();
        bus.rsp_ready = 1'b1;
        wait_for(1, 5, "t4_req1_grant", g2);
        chk("t4_regrant_cycle", g2 - r, 12);
        step();
        bus.req1_valid = 1'b0;
        wait_for(2, 60, "t4_rsp2", r2);
        chk("t4_rsp2_id", bus.rsp_id, 1);
        chk("t4_rsp2_data", bus.rsp_data, 16'hBEEF);

        // Reset while capturing result bit 7.
        step();
        cfg_wl = 3;
        cfg_res = 16'hCAFE;
        bus.req0_a = 16'h1357;
        bus.req0_b = 16'h0003;
        bus.req0_valid = 1'b1;
        wait_for(0, 5, "t5_grant", g);
        step();
        bus.req0_valid = 1'b0;
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cyc == g + 1 + W + 3 + 7) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL t5_reach_capture: target cycle not reached");
        end
        #2 res = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        chk("t5_rsp_data", bus.rsp_data, 0);
        chk("t5_rsp_err", bus.rsp_err, 0);
        chk("t5_rsp_id", bus.rsp_id, 0);
        chk("t5_tvalid", bus.alu_tvalid, 0);
        chk("t5_alu_a", bus.alu_a, 0);
        chk("t5_alu_b", bus.alu_b, 0);
        chk("t5_ready0", bus.req0_ready, 0);
        chk("t5_ready1", bus.req1_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1 res = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) cnt++;
        end
        chk("t5_no_response", cnt, 0);
        step();
        cfg_wl = 1;
        cfg_res = 16'h0F0F;
        bus.req0_a = 16'h2222;
        bus.req0_b = 16'h0002;
        bus.req0_valid = 1'b1;
        wait_for(0, 3, "t5_fresh_grant", g);
        step();
        bus.req0_valid = 1'b0;
        wait_for(2, 60, "t5_fresh_rsp", r);
        chk("t5_fresh_data", bus.rsp_data, 16'h0F0F);
        chk("t5_fresh_latency", r - g, 34);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
